display_scanout: RTL
====================

DISPLAY_SCANOUT -- requirements
Module: display_scanout

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line below.
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 96, front porch pixels
- H_SYNC, 64, hsync width in pixels
- H_BACK, 58, back porch pixels
- V_ACTIVE, 400, visible lines
- V_FRONT, 87, front porch lines
- V_SYNC, 6, vsync width in lines
- V_BACK, 32, back porch lines
- CLK_DIV, 2, clk cycles per pixel; even, >=2
- SYNC_ACTIVE_HIGH, 0, sync polarity
- Y_W, 4 / C_W, 3, luma / chroma widths
- ADDR_W, 18, framebuffer address width

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line below.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scan-out request, sampled at frame boundary
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- clock_out  out  1  pixel clock to panel
- y  out  Y_W  luma
- cr  out  C_W  red chroma
- cb  out  C_W  blue chroma
- de  out  1  data enable, high on active pixels
- rd_addr  out  ADDR_W  framebuffer read address
- rd_en  out  1  one-clk read strobe
- color  in  Y_W+2*C_W  pixel data {y,cr,cb}
- ready  in  1  color valid
- frame_start  out  1  one-clk pulse at the start of frame
- underflow  out  1  sticky; pixel missed in current frame

Function
REQ-003 The block SHALL define the pixel tick as div==CLK_DIV-1, with div counting 0..CLK_DIV-1 every clk while running.
REQ-004 clock_out SHALL be high when div>=CLK_DIV/2, and low while stopped or in reset.
REQ-005 h SHALL count 0..H_TOTAL-1 on pixel ticks, where H_TOTAL=H_SYNC+H_BACK+H_ACTIVE+H_FRONT.
REQ-006 v SHALL increment when h wraps, counting 0..V_TOTAL-1 (defined likewise).
REQ-007 Region order SHALL be sync, back porch, active, front porch; active means h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and v in the same form.
REQ-008 hsync SHALL be asserted (per polarity) for h<H_SYNC; vsync SHALL be asserted for v<V_SYNC.
REQ-009 All outputs SHALL be registered, updated on the pixel tick for position (h,v), and valid from the next clk.
REQ-010 On the pixel tick preceding each active pixel, the block SHALL:
- pulse rd_en for one clk;
- drive rd_addr = (v-V_SYNC-V_BACK)*H_ACTIVE + (h-H_SYNC-H_BACK) for that pixel.
REQ-011 rd_addr SHALL increment linearly across lines without gaps and hold its value between strobes.
REQ-012 On an active pixel tick:
- with ready=1, {y,cr,cb} SHALL take color and de SHALL be 1;
- with ready=0, the outputs SHALL take the blank value (y=0, cr=cb=2^(C_W-1)), de SHALL be 1 and underflow SHALL set.
REQ-013 Outside active regions, the outputs SHALL be the blank value and de=0.
REQ-014 The block SHALL have two states:
- STOPPED: counters at 0, syncs deasserted, clock_out low;
- RUN.
REQ-015 STOPPED->RUN SHALL occur on the first clk with enable=1; that clk SHALL produce the frame_start pulse, and the first pixel tick follows CLK_DIV clks later.
REQ-016 RUN->STOPPED SHALL occur only at the final pixel tick of a frame (h=H_TOTAL-1, v=V_TOTAL-1) with enable=0; a mid-frame enable drop SHALL complete the frame.
REQ-017 In RUN, frame_start SHALL pulse on the clk following the final pixel tick; underflow SHALL clear on the same clk as frame_start.
REQ-018 Counter widths SHALL be sized by $clog2 of the totals; address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-019 While reset=1, the block SHALL force STOPPED with:
- div=h=v=0 and rd_addr=0;
- rd_en=0, de=0, frame_start=0, underflow=0;
- blank color;
- syncs deasserted, clock_out=0.
REQ-020 Reset SHALL be honoured at any clk, mid-frame included, and recovery SHALL follow REQ-015.

Verification
Bench parameters for all scenarios: H 4/1/2/1, V 3/1/1/1 (H_TOTAL=8, V_TOTAL=6), CLK_DIV=2, SYNC_ACTIVE_HIGH=0, ready=1 unless stated.
REQ-021 Start scenario: enable=1 after reset -> frame_start at clk 1; clock_out period 2 clk; hsync low for h=0..1 (4 clk); vsync low for line 0 (16 clk).
REQ-022 Addressing scenario: full frame -> 12 rd_en strobes with rd_addr 0..11; de high for 4 pixels on lines 2..4; rd_addr returns to 0 in the next frame.
REQ-023 Underflow scenario: ready=0 on pixel (1,0) -> y=0, cr=cb=4, de=1, underflow=1 until next frame_start, then 0.
REQ-024 Stop scenario: enable dropped mid-frame -> frame completes; then STOPPED, clock_out low, no further frame_start; enable re-raised -> restart per REQ-015.
REQ-025 Reset scenario: reset asserted mid-active-line -> next clk all outputs at reset values; rd_addr=0.
REQ-026 Timing scenario: CLK_DIV=4 and SYNC_ACTIVE_HIGH=1 -> pixel period 4 clk, clock_out 2 high/2 low, hsync high for 8 clk per line.

Source files
------------

// File: rtl/display_scanout.sv
`default_nettype none
// ============================================================================
// Module      : display_scanout
// Description : Raster timing generator and framebuffer scan-out engine.
//               A pixel-rate tick derived from clk walks an (h, v) raster
//               of sync / back porch / active / front porch regions. The
//               framebuffer read for each active pixel is issued one pixel
//               tick early, and the returned colour is registered on the
//               pixel's own tick. Missing data is replaced by the blank
//               colour and flagged as a sticky per-frame underflow.
// Ports       : clk, reset       - system clock, synchronous active-high reset
//               enable           - scan-out request, sampled at frame boundary
//               hsync, vsync     - sync outputs, polarity per SYNC_ACTIVE_HIGH
//               clock_out        - pixel clock to the panel
//               y, cr, cb, de    - registered pixel data and data enable
//               rd_addr, rd_en   - framebuffer read address and strobe
//               color, ready     - framebuffer return data {y,cr,cb}, valid
//               frame_start      - one-clk pulse at the start of each frame
//               underflow        - sticky, a pixel was missed this frame
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanout #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FRONT          = 96,
    parameter int H_SYNC           = 64,
    parameter int H_BACK           = 58,
    parameter int V_ACTIVE         = 400,
    parameter int V_FRONT          = 87,
    parameter int V_SYNC           = 6,
    parameter int V_BACK           = 32,
    parameter int CLK_DIV          = 2,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int Y_W              = 4,
    parameter int C_W              = 3,
    parameter int ADDR_W           = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     clock_out,
    output logic [Y_W-1:0]           y,
    output logic [C_W-1:0]           cr,
    output logic [C_W-1:0]           cb,
    output logic                     de,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_en,
    input  logic [Y_W+2*C_W-1:0]     color,
    input  logic                     ready,
    output logic                     frame_start,
    output logic                     underflow
);

    localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int DW          = $clog2(CLK_DIV);
    localparam int H_ACT_START = H_SYNC + H_BACK;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    localparam logic           SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
    localparam logic           SYNC_OFF = !SYNC_ON;
    localparam logic [C_W-1:0] BLANK_C  = C_W'(1) << (C_W - 1);

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } state_t;

    state_t            state;
    logic [DW-1:0]     div;
    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [ADDR_W-1:0] next_addr;   // address of the next active pixel to fetch

    logic          tick;
    logic          h_last;
    logic          v_last;
    logic          frame_end;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          pix_active;
    logic          fetch_next;
    logic          run_nxt;
    logic [DW-1:0] div_nxt;
    logic          clock_nxt;

    function automatic logic is_active(input int hh, input int vv);
        return (hh >= H_ACT_START) && (hh < H_ACT_END) &&
               (vv >= V_ACT_START) && (vv < V_ACT_END);
    endfunction

    always_comb begin
        tick       = (state == RUN) && (div == DW'(CLK_DIV - 1));
        h_last     = (int'(h) == H_TOTAL - 1);
        v_last     = (int'(v) == V_TOTAL - 1);
        frame_end  = h_last && v_last;
        h_nxt      = h_last ? '0 : h + HW'(1);
        v_nxt      = v;
        if (h_last) begin
            v_nxt = v_last ? '0 : v + VW'(1);
        end
        pix_active = is_active(int'(h), int'(v));
        // The read for a pixel is issued on the tick of the pixel before it.
        fetch_next = is_active(int'(h_nxt), int'(v_nxt));

        // State and divider as they will be after this clk, so that the
        // registered clock_out tracks the divider phase without lag.
        run_nxt = 1'b0;
        div_nxt = '0;
        if (state == RUN) begin
            run_nxt = !(tick && frame_end && !enable);
            div_nxt = tick ? '0 : div + DW'(1);
        end else begin
            run_nxt = enable;
        end
        clock_nxt = run_nxt && (int'(div_nxt) >= CLK_DIV / 2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STOPPED;
            div         <= '0;
            h           <= '0;
            v           <= '0;
            next_addr   <= '0;
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            y           <= '0;
            cr          <= BLANK_C;
            cb          <= BLANK_C;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            clock_out   <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            frame_start <= 1'b0;
            div         <= div_nxt;
            clock_out   <= clock_nxt;
            case (state)
                STOPPED: begin
                    if (enable) begin
                        state       <= RUN;
                        frame_start <= 1'b1;
                        underflow   <= 1'b0;
                        next_addr   <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        h     <= h_nxt;
                        v     <= v_nxt;
                        hsync <= (int'(h) < H_SYNC) ? SYNC_ON : SYNC_OFF;
                        vsync <= (int'(v) < V_SYNC) ? SYNC_ON : SYNC_OFF;
                        de    <= pix_active;
                        if (pix_active && ready) begin
                            {y, cr, cb} <= color;
                        end else begin
                            y  <= '0;
                            cr <= BLANK_C;
                            cb <= BLANK_C;
                        end
                        if (pix_active && !ready) begin
                            underflow <= 1'b1;
                        end
                        if (fetch_next) begin
                            rd_en     <= 1'b1;
                            rd_addr   <= next_addr;
                            next_addr <= next_addr + ADDR_W'(1);
                        end
                        // The last raster position is never active, so the
                        // frame-boundary updates cannot collide with a fetch
                        // or an underflow set.
                        if (frame_end) begin
                            next_addr <= '0;
                            if (enable) begin
                                frame_start <= 1'b1;
                                underflow   <= 1'b0;
                            end else begin
                                state <= STOPPED;
                            end
                        end
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end

endmodule
`default_nettype wire
